// File: rtl/reminder_sequencer.sv
// Hydration-reminder sequencer: turns the interval timer's request into
// alert / snooze / escalation phases and restarts the timer when the user drinks.
module reminder_sequencer #(
    parameter int ALERT_TICKS  = 60,
    parameter int SNOOZE_TICKS = 300,
    parameter int MAX_SNOOZES  = 3,
    parameter int BLINK_TICKS  = 1,
    parameter int MISS_W       = 4,
    localparam int SNZ_W = (MAX_SNOOZES > 0) ? $clog2(MAX_SNOOZES + 1) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tick,
    input  logic              remind_req,
    input  logic              drank,
    input  logic              snooze_btn,
    output logic              alert,
    output logic              blink,
    output logic              urgent,
    output logic              snooze_active,
    output logic              timer_clear,
    output logic [SNZ_W-1:0]  snoozes_left,
    output logic [MISS_W-1:0] missed_count,
    output logic [1:0]        state
);

    // state     | meaning
    // S_IDLE    | waiting for the interval timer
    // S_ALERT   | reminder shown, counting down to escalation
    // S_SNOOZE  | reminder hidden for SNOOZE_TICKS
    // S_ESC     | escalated, held until the user drinks
    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ALERT  = 2'd1,
        S_SNOOZE = 2'd2,
        S_ESC    = 2'd3
    } state_t;

    localparam int CNT_MAX = (ALERT_TICKS > SNOOZE_TICKS) ? ALERT_TICKS : SNOOZE_TICKS;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int BLK_W   = $clog2(BLINK_TICKS + 1);
    localparam logic [MISS_W-1:0] MISS_SAT = '1;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [BLK_W-1:0]   bcnt_q, bcnt_d;
    logic               blink_q, blink_d;
    logic               alert_q, alert_d;
    logic               urgent_q, urgent_d;
    logic               snz_act_q, snz_act_d;
    logic               clear_q, clear_d;
    logic [SNZ_W-1:0]   snz_q, snz_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    logic               expire;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bcnt_d  = bcnt_q;
        blink_d = blink_q;
        snz_d   = snz_q;
        miss_d  = miss_q;
        clear_d = 1'b0;
        expire  = tick && (cnt_q == CNT_W'(1));

        case (state_q)
            S_IDLE: begin
                if (drank) begin
                    clear_d = 1'b1;
                    snz_d   = SNZ_W'(MAX_SNOOZES);
                end else if (remind_req) begin
                    state_d = S_ALERT;
                    cnt_d   = CNT_W'(ALERT_TICKS);
                    bcnt_d  = BLK_W'(BLINK_TICKS);
                    blink_d = 1'b1;
                end
            end
            S_ALERT: begin
                if (drank) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    snz_d   = SNZ_W'(MAX_SNOOZES);
                    blink_d = 1'b0;
                end else if (snooze_btn && (snz_q != '0)) begin
                    state_d = S_SNOOZE;
                    snz_d   = snz_q - SNZ_W'(1);
                    cnt_d   = CNT_W'(SNOOZE_TICKS);
                    blink_d = 1'b0;
                end else if (expire) begin
                    state_d = S_ESC;
                    blink_d = 1'b1;
                    if (miss_q != MISS_SAT) miss_d = miss_q + MISS_W'(1);
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                    // blink reloads its own half-period counter independently of the alert timer
                    if (bcnt_q == BLK_W'(1)) begin
                        blink_d = ~blink_q;
                        bcnt_d  = BLK_W'(BLINK_TICKS);
                    end else begin
                        bcnt_d = bcnt_q - BLK_W'(1);
                    end
                end
            end
            S_SNOOZE: begin
                if (drank) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    snz_d   = SNZ_W'(MAX_SNOOZES);
                end else if (expire) begin
                    state_d = S_ALERT;
                    cnt_d   = CNT_W'(ALERT_TICKS);
                    bcnt_d  = BLK_W'(BLINK_TICKS);
                    blink_d = 1'b1;
                end else if (tick) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_ESC: begin
                if (drank) begin
                    state_d = S_IDLE;
                    clear_d = 1'b1;
                    snz_d   = SNZ_W'(MAX_SNOOZES);
                    blink_d = 1'b0;
                end else if (tick) begin
                    blink_d = ~blink_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        alert_d   = (state_d == S_ALERT) || (state_d == S_ESC);
        urgent_d  = (state_d == S_ESC);
        snz_act_d = (state_d == S_SNOOZE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            bcnt_q    <= '0;
            blink_q   <= 1'b0;
            alert_q   <= 1'b0;
            urgent_q  <= 1'b0;
            snz_act_q <= 1'b0;
            clear_q   <= 1'b0;
            snz_q     <= SNZ_W'(MAX_SNOOZES);
            miss_q    <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bcnt_q    <= bcnt_d;
            blink_q   <= blink_d;
            alert_q   <= alert_d;
            urgent_q  <= urgent_d;
            snz_act_q <= snz_act_d;
            clear_q   <= clear_d;
            snz_q     <= snz_d;
            miss_q    <= miss_d;
        end
    end

    assign state         = state_q;
    assign alert         = alert_q;
    assign blink         = blink_q;
    assign urgent        = urgent_q;
    assign snooze_active = snz_act_q;
    assign timer_clear   = clear_q;
    assign snoozes_left  = snz_q;
    assign missed_count  = miss_q;

endmodule

// File: tb/tb_reminder_sequencer.sv
// Randomised + directed bench for reminder_sequencer; a reference model pushes
// expected outputs into a queue and a negedge monitor compares them.
module tb_reminder_sequencer;

    localparam int AT   = 4;
    localparam int ST   = 3;
    localparam int MAXS = 2;
    localparam int BT   = 2;
    localparam int MW   = 4;
    localparam int MISS_MAX = (1 << MW) - 1;

    logic       clk = 1'b0;
    logic       reset, tick, remind_req, drank, snooze_btn;
    logic       alert, blink, urgent, snooze_active, timer_clear;
    logic [1:0] snoozes_left;
    logic [MW-1:0] missed_count;
    logic [1:0] state;

    reminder_sequencer #(
        .ALERT_TICKS(AT), .SNOOZE_TICKS(ST), .MAX_SNOOZES(MAXS),
        .BLINK_TICKS(BT), .MISS_W(MW)
    ) dut (
        .clk(clk), .reset(reset), .tick(tick), .remind_req(remind_req),
        .drank(drank), .snooze_btn(snooze_btn), .alert(alert), .blink(blink),
        .urgent(urgent), .snooze_active(snooze_active), .timer_clear(timer_clear),
        .snoozes_left(snoozes_left), .missed_count(missed_count), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        int            cyc;
        logic [1:0]    st;
        logic          al, bl, ur, sa, tc;
        logic [1:0]    sl;
        logic [MW-1:0] mc;
    } exp_t;

    exp_t exp_q[$];
    int   cyc_cnt = 0;
    int   errors  = 0;
    int   checks  = 0;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference model: mode plus ticks elapsed since entering that mode.
    int m_mode = 0, m_el = 0, m_left = MAXS, m_miss = 0;
    bit m_clear = 0;

    task automatic back_to_idle();
        m_mode = 0; m_el = 0; m_clear = 1; m_left = MAXS;
    endtask

    task automatic model_step(input bit r, input bit t, input bit q, input bit d, input bit s);
        m_clear = 0;
        if (r) begin
            m_mode = 0; m_el = 0; m_left = MAXS; m_miss = 0;
        end else begin
            case (m_mode)
                0: if (d) m_clear = 1;
                   else if (q) begin m_mode = 1; m_el = 0; end
                1: if (d) back_to_idle();
                   else if (s && m_left > 0) begin m_mode = 2; m_left--; m_el = 0; end
                   else if (t) begin
                       m_el++;
                       if (m_el == AT) begin
                           m_mode = 3; m_el = 0;
                           if (m_miss < MISS_MAX) m_miss++;
                       end
                   end
                2: if (d) back_to_idle();
                   else if (t) begin
                       m_el++;
                       if (m_el == ST) begin m_mode = 1; m_el = 0; end
                   end
                default: if (d) back_to_idle();
                   else if (t) m_el++;
            endcase
        end
    endtask

    task automatic drive(input bit r, input bit t, input bit q, input bit d, input bit s);
        exp_t e;
        reset = r; tick = t; remind_req = q; drank = d; snooze_btn = s;
        model_step(r, t, q, d, s);
        e.cyc = cyc_cnt + 1;
        e.st  = 2'(m_mode);
        e.al  = (m_mode == 1) || (m_mode == 3);
        e.bl  = (m_mode == 1) ? (((m_el / BT) % 2) == 0) :
                (m_mode == 3) ? ((m_el % 2) == 0) : 1'b0;
        e.ur  = (m_mode == 3);
        e.sa  = (m_mode == 2);
        e.tc  = m_clear;
        e.sl  = 2'(m_left);
        e.mc  = MW'(m_miss);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0);
    endtask

    task automatic ticks_n(input int n);
        for (int i = 0; i < n; i++) begin
            drive(0, 1, 0, 0, 0);
            drive(0, 0, 0, 0, 0);
        end
    endtask

    always @(negedge clk) begin
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (state !== e.st || alert !== e.al || blink !== e.bl || urgent !== e.ur ||
                snooze_active !== e.sa || timer_clear !== e.tc ||
                snoozes_left !== e.sl || missed_count !== e.mc) begin
                errors++;
                $display("FAIL outputs cyc=%0d got st=%0d al=%0b bl=%0b ur=%0b sa=%0b tc=%0b sl=%0d mc=%0d want st=%0d al=%0b bl=%0b ur=%0b sa=%0b tc=%0b sl=%0d mc=%0d",
                         e.cyc, state, alert, blink, urgent, snooze_active, timer_clear,
                         snoozes_left, missed_count, e.st, e.al, e.bl, e.ur, e.sa, e.tc,
                         e.sl, e.mc);
            end
        end
    end

    initial begin
        // reset and idle
        drive(1, 0, 0, 0, 0);
        drive(1, 0, 0, 0, 0);
        idle_n(2);
        // drink after two alert ticks
        drive(0, 0, 1, 0, 0);
        ticks_n(2);
        drive(0, 0, 0, 1, 0);
        idle_n(2);
        // early drink in idle restarts the timer
        drive(0, 0, 0, 1, 0);
        idle_n(1);
        // timeout escalation, blink in escalation, then drink
        drive(0, 0, 1, 0, 0);
        ticks_n(AT + 3);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 1, 0);
        idle_n(1);
        // two snoozes, third press ignored, then escalation
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 1);
        ticks_n(ST);
        drive(0, 0, 0, 0, 1);
        ticks_n(ST);
        drive(0, 0, 0, 0, 1);
        ticks_n(AT);
        drive(0, 0, 0, 1, 0);
        idle_n(1);
        // drink coincides with the expiring tick
        drive(0, 0, 1, 0, 0);
        ticks_n(AT - 1);
        drive(0, 1, 0, 1, 0);
        idle_n(1);
        // saturation of the missed counter
        for (int k = 0; k < 16; k++) begin
            drive(0, 0, 1, 0, 0);
            ticks_n(AT);
            drive(0, 0, 0, 1, 0);
        end
        idle_n(1);
        // reset mid-snooze, request while alerting is dropped
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 0, 0, 1);
        ticks_n(1);
        drive(1, 0, 0, 0, 0);
        idle_n(1);
        drive(0, 0, 1, 0, 0);
        drive(0, 0, 1, 0, 0);
        drive(0, 1, 1, 0, 0);
        idle_n(2);
        // random traffic
        for (int i = 0; i < 4000; i++) begin
            drive(($urandom_range(0, 599) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 5) == 0),
                  ($urandom_range(0, 39) == 0),
                  ($urandom_range(0, 11) == 0));
        end
        idle_n(3);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain pending=%0d want 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
